// File: rtl/clk_step_ctrl_pkg.sv
// Shared encodings and default widths for the processor clock-step controller.
package clk_step_ctrl_pkg;

   localparam int unsigned DIV_W_DEF      = 8;
   localparam int unsigned CNT_W_DEF      = 32;
   localparam int unsigned DEB_CYCLES_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10,
      ST_HALT = 2'b11
   } state_t;

endpackage

// File: rtl/step_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-sample debounce and
// a one-cycle pulse on each rising edge of the debounced level.
module step_debounce #(
   parameter int unsigned DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic pulse_c
);

   localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic          level_q;
   logic [CW-1:0] stable_cnt;

   // Level flips only after DEB_CYCLES consecutive samples disagreeing with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         level      <= 1'b0;
         level_q    <= 1'b0;
         stable_cnt <= '0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         level_q <= level;
         if (sync2 == level) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CW'(DEB_CYCLES - 1)) begin
            level      <= sync2;
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + CW'(1);
         end
      end
   end

   assign pulse_c = level & ~level_q;

endmodule

// File: rtl/clk_step_ctrl.sv
// Clock-step controller: run / divided run / debounced single-step / halt,
// issuing registered CPU_EN pulses and a saturating retired-cycle counter.
// Optional breakpoint halt enabled by defining CLK_STEP_BREAKPOINT_EN.
module clk_step_ctrl
   import clk_step_ctrl_pkg::*;
#(
   parameter int unsigned DIV_W      = DIV_W_DEF,
   parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             RUN,
   input  logic             STEP,
   input  logic [DIV_W-1:0] DIV,
   input  logic             HALT_REQ,
   input  logic             CLR_HALT,
`ifdef CLK_STEP_BREAKPOINT_EN
   input  logic [CNT_W-1:0] BRK_CYCLE,
   input  logic             BRK_ARM,
`endif
   output logic             CPU_EN,
   output logic [1:0]       STATE,
   output logic             HALTED,
   output logic [CNT_W-1:0] CYCLE_CNT
);

   state_t           state;
   state_t           state_nxt;
   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_nxt;
   logic             en_nxt;
   logic             step_pls_c;
   logic             halt_c;
   logic [CNT_W-1:0] cnt_inc_c;

   step_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_step_debounce (
      .clk    (CLK),
      .rst_n  (RST_N),
      .raw    (STEP),
      .pulse_c(step_pls_c)
   );

   assign cnt_inc_c = (CYCLE_CNT == '1) ? CYCLE_CNT : CYCLE_CNT + CNT_W'(1);

`ifdef CLK_STEP_BREAKPOINT_EN
   logic brk_armed;
   logic brk_arm_q;
   logic brk_hit_c;

   assign brk_hit_c = brk_armed & CPU_EN & (cnt_inc_c == BRK_CYCLE);
   assign halt_c    = CPU_EN & (HALT_REQ | brk_hit_c);

   // Arms on a BRK_ARM rising edge, disarms once the breakpoint fires
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         brk_armed <= 1'b0;
         brk_arm_q <= 1'b0;
      end else begin
         brk_arm_q <= BRK_ARM;
         if (BRK_ARM && !brk_arm_q) begin
            brk_armed <= 1'b1;
         end else if (brk_hit_c) begin
            brk_armed <= 1'b0;
         end
      end
   end
`else
   assign halt_c = CPU_EN & HALT_REQ;
`endif

   always_comb begin
      state_nxt = state;
      div_nxt   = div_cnt;
      en_nxt    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (RUN) begin
               state_nxt = ST_RUN;
               div_nxt   = '0;
            end else if (step_pls_c) begin
               state_nxt = ST_STEP;
               en_nxt    = 1'b1;
            end
         end
         ST_RUN: begin
            if (!RUN) begin
               state_nxt = ST_IDLE;
            end else if (div_cnt == DIV) begin
               div_nxt = '0;
               en_nxt  = 1'b1;
            end else begin
               div_nxt = div_cnt + DIV_W'(1);
            end
         end
         ST_STEP: state_nxt = ST_IDLE;
         ST_HALT: begin
            if (CLR_HALT) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // Halt request seen on an issued pulse overrides every other transition
      if (halt_c) begin
         state_nxt = ST_HALT;
         en_nxt    = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= ST_IDLE;
         div_cnt   <= '0;
         CPU_EN    <= 1'b0;
         HALTED    <= 1'b0;
         CYCLE_CNT <= '0;
      end else begin
         state   <= state_nxt;
         div_cnt <= div_nxt;
         CPU_EN  <= en_nxt;
         HALTED  <= (state_nxt == ST_HALT);
         if (CPU_EN) begin
            CYCLE_CNT <= cnt_inc_c;
         end
      end
   end

   assign STATE = state;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed self-checking bench for clk_step_ctrl (32-bit and 4-bit counter builds).
module tb_clk_step_ctrl;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic        step;
   logic [7:0]  div;
   logic        halt_req;
   logic        clr_halt;
   logic        cpu_en;
   logic [1:0]  state;
   logic        halted;
   logic [31:0] cycle_cnt;
   logic        en4;
   logic [1:0]  state4;
   logic        halted4;
   logic [3:0]  cnt4;
`ifdef CLK_STEP_BREAKPOINT_EN
   logic [31:0] brk_cycle;
   logic [3:0]  brk_cycle4;
   logic        brk_arm;
`endif

   int checks;
   int errors;

   clk_step_ctrl #(.DIV_W(8), .DEB_CYCLES(4), .CNT_W(32)) dut (
      .CLK      (clk),
      .RST_N    (rst_n),
      .RUN      (run),
      .STEP     (step),
      .DIV      (div),
      .HALT_REQ (halt_req),
      .CLR_HALT (clr_halt),
`ifdef CLK_STEP_BREAKPOINT_EN
      .BRK_CYCLE(brk_cycle),
      .BRK_ARM  (brk_arm),
`endif
      .CPU_EN   (cpu_en),
      .STATE    (state),
      .HALTED   (halted),
      .CYCLE_CNT(cycle_cnt)
   );

   clk_step_ctrl #(.DIV_W(8), .DEB_CYCLES(4), .CNT_W(4)) dut4 (
      .CLK      (clk),
      .RST_N    (rst_n),
      .RUN      (run),
      .STEP     (step),
      .DIV      (div),
      .HALT_REQ (halt_req),
      .CLR_HALT (clr_halt),
`ifdef CLK_STEP_BREAKPOINT_EN
      .BRK_CYCLE(brk_cycle4),
      .BRK_ARM  (brk_arm),
`endif
      .CPU_EN   (en4),
      .STATE    (state4),
      .HALTED   (halted4),
      .CYCLE_CNT(cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_reset;
      run      = 1'b0;
      step     = 1'b0;
      div      = 8'd0;
      halt_req = 1'b0;
      clr_halt = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      apply_reset();
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (state !== 2'b00 || cpu_en !== 1'b0 || halted !== 1'b0 || cycle_cnt !== 32'd0) begin
         $display("FAIL reset: state=%b en=%b halted=%b cnt=%0d, want 00 0 0 0",
                  state, cpu_en, halted, cycle_cnt);
         errors++;
      end
      checks++;
      if (state4 !== 2'b00 || en4 !== 1'b0 || halted4 !== 1'b0 || cnt4 !== 4'd0) begin
         $display("FAIL reset_cnt4: state=%b en=%b halted=%b cnt=%0d, want 00 0 0 0",
                  state4, en4, halted4, cnt4);
         errors++;
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (state !== 2'b00 || cpu_en !== 1'b0) begin
         $display("FAIL idle_hold: state=%b en=%b, want 00 0", state, cpu_en);
         errors++;
      end
   endtask

   task automatic test_run_div0;
      apply_reset();
      run = 1'b1;
      div = 8'd0;
      @(negedge clk);
      checks++;
      if (state !== 2'b01 || cpu_en !== 1'b0) begin
         $display("FAIL run_entry: state=%b en=%b, want 01 0", state, cpu_en);
         errors++;
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (cpu_en !== 1'b1 || cycle_cnt !== 32'(i)) begin
            $display("FAIL run_div0[%0d]: en=%b cnt=%0d, want 1 %0d", i, cpu_en, cycle_cnt, i);
            errors++;
         end
      end
      @(negedge clk);
      checks++;
      if (cycle_cnt !== 32'd10) begin
         $display("FAIL run_cnt10: cnt=%0d, want 10", cycle_cnt);
         errors++;
      end
      run = 1'b0;
      @(negedge clk);
      checks++;
      if (state !== 2'b00 || cpu_en !== 1'b0 || cycle_cnt !== 32'd11) begin
         $display("FAIL run_stop: state=%b en=%b cnt=%0d, want 00 0 11", state, cpu_en, cycle_cnt);
         errors++;
      end
   endtask

   task automatic test_run_div3;
      logic exp;
      apply_reset();
      run = 1'b1;
      div = 8'd3;
      @(negedge clk);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         exp = (k == 4) || (k == 8) || (k == 10) || (k == 12) || (k == 14);
         checks++;
         if (cpu_en !== exp) begin
            $display("FAIL run_div[%0d]: en=%b, want %b", k, cpu_en, exp);
            errors++;
         end
         if (k == 8) div = 8'd1;
      end
      checks++;
      if (cycle_cnt !== 32'd4) begin
         $display("FAIL run_div_cnt: cnt=%0d, want 4", cycle_cnt);
         errors++;
      end
      run = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_step;
      apply_reset();
      step = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         checks++;
         if (cpu_en !== (k == 7)) begin
            $display("FAIL step_press[%0d]: en=%b, want %b", k, cpu_en, (k == 7));
            errors++;
         end
         if (k == 7 || k == 8) begin
            checks++;
            if (state !== ((k == 7) ? 2'b10 : 2'b00)) begin
               $display("FAIL step_state[%0d]: state=%b, want %b", k, state,
                        ((k == 7) ? 2'b10 : 2'b00));
               errors++;
            end
         end
      end
      step = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         checks++;
         if (cpu_en !== 1'b0) begin
            $display("FAIL step_release[%0d]: en=%b, want 0", k, cpu_en);
            errors++;
         end
      end
      checks++;
      if (cycle_cnt !== 32'd1) begin
         $display("FAIL step_cnt: cnt=%0d, want 1", cycle_cnt);
         errors++;
      end
      // 2-clock glitch
      step = 1'b1;
      @(negedge clk);
      @(negedge clk);
      step = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         checks++;
         if (cpu_en !== 1'b0 || state !== 2'b00) begin
            $display("FAIL step_glitch[%0d]: en=%b state=%b, want 0 00", k, cpu_en, state);
            errors++;
         end
      end
      checks++;
      if (cycle_cnt !== 32'd1) begin
         $display("FAIL glitch_cnt: cnt=%0d, want 1", cycle_cnt);
         errors++;
      end
      // RUN rising in the same cycle as the step pulse: RUN wins
      step = 1'b1;
      for (int k = 1; k <= 6; k++) @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      checks++;
      if (state !== 2'b01 || cpu_en !== 1'b0) begin
         $display("FAIL run_vs_step: state=%b en=%b, want 01 0", state, cpu_en);
         errors++;
      end
      @(negedge clk);
      checks++;
      if (cpu_en !== 1'b1) begin
         $display("FAIL run_vs_step_en: en=%b, want 1", cpu_en);
         errors++;
      end
      run  = 1'b0;
      step = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_halt;
      apply_reset();
      run = 1'b1;
      div = 8'd0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (cpu_en !== 1'b1) begin
         $display("FAIL halt_pre_en: en=%b, want 1", cpu_en);
         errors++;
      end
      halt_req = 1'b1;
      @(negedge clk);
      checks++;
      if (state !== 2'b11 || halted !== 1'b1 || cpu_en !== 1'b0) begin
         $display("FAIL halt_enter: state=%b halted=%b en=%b, want 11 1 0", state, halted, cpu_en);
         errors++;
      end
      halt_req = 1'b0;
      step     = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         checks++;
         if (state !== 2'b11 || halted !== 1'b1 || cpu_en !== 1'b0) begin
            $display("FAIL halt_hold[%0d]: state=%b halted=%b en=%b, want 11 1 0",
                     k, state, halted, cpu_en);
            errors++;
         end
      end
      step = 1'b0;
      repeat (8) @(negedge clk);
      run      = 1'b0;
      clr_halt = 1'b1;
      @(negedge clk);
      clr_halt = 1'b0;
      checks++;
      if (state !== 2'b00 || halted !== 1'b0) begin
         $display("FAIL halt_clear: state=%b halted=%b, want 00 0", state, halted);
         errors++;
      end
      // HALT_REQ ignored without a pulse; CLR_HALT ignored outside HALT
      halt_req = 1'b1;
      clr_halt = 1'b1;
      @(negedge clk);
      clr_halt = 1'b0;
      checks++;
      if (state !== 2'b00 || halted !== 1'b0) begin
         $display("FAIL halt_no_pulse: state=%b halted=%b, want 00 0", state, halted);
         errors++;
      end
      // Halt overrides the step return to IDLE
      step = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 7) begin
            checks++;
            if (state !== 2'b10 || cpu_en !== 1'b1) begin
               $display("FAIL halt_step_pulse: state=%b en=%b, want 10 1", state, cpu_en);
               errors++;
            end
         end
         if (k == 8) begin
            checks++;
            if (state !== 2'b11 || halted !== 1'b1 || cpu_en !== 1'b0) begin
               $display("FAIL halt_from_step: state=%b halted=%b en=%b, want 11 1 0",
                        state, halted, cpu_en);
               errors++;
            end
         end
      end
      halt_req = 1'b0;
      step     = 1'b0;
      repeat (8) @(negedge clk);
      clr_halt = 1'b1;
      @(negedge clk);
      clr_halt = 1'b0;
      checks++;
      if (state !== 2'b00 || halted !== 1'b0) begin
         $display("FAIL halt_clear2: state=%b halted=%b, want 00 0", state, halted);
         errors++;
      end
   endtask

   task automatic test_saturate;
      apply_reset();
      run = 1'b1;
      div = 8'd0;
      @(negedge clk);
      for (int k = 1; k <= 22; k++) begin
         @(negedge clk);
         if (k == 21) begin
            checks++;
            if (cycle_cnt !== 32'd20) begin
               $display("FAIL sat_cnt32: cnt=%0d, want 20", cycle_cnt);
               errors++;
            end
         end
         if (k >= 16) begin
            checks++;
            if (cnt4 !== 4'hF || en4 !== 1'b1) begin
               $display("FAIL sat_cnt4[%0d]: cnt=%h en=%b, want f 1", k, cnt4, en4);
               errors++;
            end
         end
      end
      run = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_async_reset;
      apply_reset();
      run = 1'b1;
      div = 8'd0;
      repeat (4) @(negedge clk);
      checks++;
      if (cpu_en !== 1'b1 || cycle_cnt !== 32'd2) begin
         $display("FAIL areset_pre: en=%b cnt=%0d, want 1 2", cpu_en, cycle_cnt);
         errors++;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (cpu_en !== 1'b0 || state !== 2'b00 || halted !== 1'b0 || cycle_cnt !== 32'd0
          || en4 !== 1'b0 || cnt4 !== 4'd0) begin
         $display("FAIL areset: en=%b state=%b halted=%b cnt=%0d en4=%b cnt4=%0d, want all 0",
                  cpu_en, state, halted, cycle_cnt, en4, cnt4);
         errors++;
      end
      run = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b1;
      run      = 1'b0;
      step     = 1'b0;
      div      = 8'd0;
      halt_req = 1'b0;
      clr_halt = 1'b0;
`ifdef CLK_STEP_BREAKPOINT_EN
      brk_cycle  = 32'd0;
      brk_cycle4 = 4'd0;
      brk_arm    = 1'b0;
`endif
      #1;
      test_reset();
      test_run_div0();
      test_run_div3();
      test_step();
      test_halt();
      test_saturate();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
